// File: rtl/muxn_pipe.sv
// Parametrised N-way mux with a one-cycle registered output and valid/ready handshake.
// Optional macro MUXN_PIPE_SKID_EN adds a skid register so o_ready is registered.
module muxn_pipe #(
  parameter int unsigned NUM_INPUTS     = 4,
  parameter int unsigned MUX_DATA_WIDTH = 32,
  localparam int unsigned SEL_WIDTH     = $clog2(NUM_INPUTS)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rstn,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic [SEL_WIDTH-1:0]                 i_sel,
  input  logic [NUM_INPUTS*MUX_DATA_WIDTH-1:0] i_in,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [MUX_DATA_WIDTH-1:0]            o_muxout,
  output logic                                 o_sel_err,
  input  logic                                 i_err_clr,
  output logic                                 o_err_sticky
);

  typedef struct packed {
    logic                      err;
    logic [MUX_DATA_WIDTH-1:0] data;
  } beat_t;

`ifdef MUXN_PIPE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_t;
`endif

  state_t state_q, state_d;
  beat_t  in_beat;
  beat_t  out_q;
  logic   in_range;
  logic   valid_q;
  logic   sticky_q;
  logic   load_out;
  logic   accept;
  logic   xfer;

`ifdef MUXN_PIPE_SKID_EN
  beat_t  skid_q;
  logic   ready_q;
  logic   load_skid;
  logic   skid_to_out;

  assign o_ready = ready_q;
`else
  logic   live_q;

  // Ready is held low until the first edge after reset, then follows the output register.
  assign o_ready = live_q & (~valid_q | i_ready);
`endif

  assign accept       = i_valid & o_ready;
  assign xfer         = valid_q & i_ready;
  assign o_valid      = valid_q;
  assign o_muxout     = out_q.data;
  assign o_sel_err    = out_q.err;
  assign o_err_sticky = sticky_q;

  // Lane select; an unmatched select yields zero data and flags the beat.
  always_comb begin
    in_beat  = '0;
    in_range = 1'b0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (i_sel == SEL_WIDTH'(k)) begin
        in_beat.data = i_in[k*MUX_DATA_WIDTH +: MUX_DATA_WIDTH];
        in_range     = 1'b1;
      end
    end
    in_beat.err = ~in_range;
  end

  // Occupancy next-state and register load strobes.
  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
`ifdef MUXN_PIPE_SKID_EN
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
`endif
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d  = ONE;
          load_out = 1'b1;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          load_out = 1'b1;
        end else if (xfer) begin
          state_d = EMPTY;
`ifdef MUXN_PIPE_SKID_EN
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
`endif
        end
      end
`ifdef MUXN_PIPE_SKID_EN
      FULL: begin
        if (xfer) begin
          state_d     = ONE;
          skid_to_out = 1'b1;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
`ifdef MUXN_PIPE_SKID_EN
      ready_q <= 1'b0;
`else
      live_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
`ifdef MUXN_PIPE_SKID_EN
      ready_q <= (state_d != FULL);
`else
      live_q  <= 1'b1;
`endif
    end
  end

  // Data registers; the error flag travels with its beat.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      out_q <= '0;
    end else if (load_out) begin
      out_q <= in_beat;
`ifdef MUXN_PIPE_SKID_EN
    end else if (skid_to_out) begin
      out_q <= skid_q;
`endif
    end
  end

`ifdef MUXN_PIPE_SKID_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_beat;
    end
  end
`endif

  // Sticky error: a new error wins over a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sticky_q <= 1'b0;
    end else if (accept && in_beat.err) begin
      sticky_q <= 1'b1;
    end else if (i_err_clr) begin
      sticky_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muxn_pipe.sv
// Bench for muxn_pipe: a 4-input and a 3-input instance share stimulus and are
// checked against a queue-based model of the handshake and selection rules.
module tb_muxn_pipe;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         up_valid;
  logic [1:0]   sel;
  logic [127:0] lanes;
  logic         dn_ready;
  logic         err_clr;

  logic         rdy4, v4, e4, s4;
  logic         rdy3, v3, e3, s3;
  logic [W-1:0] d4, d3;

  always #5 clk = ~clk;

  muxn_pipe #(.NUM_INPUTS(4), .MUX_DATA_WIDTH(W)) u_dut4 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(up_valid), .o_ready(rdy4),
    .i_sel(sel), .i_in(lanes), .o_valid(v4), .i_ready(dn_ready),
    .o_muxout(d4), .o_sel_err(e4), .i_err_clr(err_clr), .o_err_sticky(s4)
  );

  muxn_pipe #(.NUM_INPUTS(3), .MUX_DATA_WIDTH(W)) u_dut3 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(up_valid), .o_ready(rdy3),
    .i_sel(sel), .i_in(lanes[95:0]), .o_valid(v3), .i_ready(dn_ready),
    .o_muxout(d3), .o_sel_err(e3), .i_err_clr(err_clr), .o_err_sticky(s3)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of accepted beats, head is the visible output.
  typedef struct {
    logic [31:0] d4;
    logic [31:0] d3;
    logic        e3;
  } beat_t;

  beat_t q[$];
  bit    live;
  bit    rdy_m;
  bit    stk3;

  task automatic model_reset();
    q.delete();
    live  = 1'b0;
    rdy_m = 1'b0;
    stk3  = 1'b0;
  endtask

  function automatic bit exp_ready();
`ifdef MUXN_PIPE_SKID_EN
    return rdy_m;
`else
    return live && (q.size() == 0 || dn_ready);
`endif
  endfunction

  function automatic beat_t make_beat(input logic [1:0] s, input logic [127:0] l);
    beat_t        b;
    logic [127:0] sh;
    sh   = l >> (32 * int'(s));
    b.d4 = sh[31:0];
    if (int'(s) < 3) begin
      b.d3 = sh[31:0];
      b.e3 = 1'b0;
    end else begin
      b.d3 = 32'd0;
      b.e3 = 1'b1;
    end
    return b;
  endfunction

  // Check the current outputs, advance the model across one rising edge, return at negedge.
  task automatic tick();
    beat_t b;
    bit    acc;
    bit    xf;
    #1;
    check("ready4", 32'(rdy4), 32'(exp_ready()));
    check("ready3", 32'(rdy3), 32'(exp_ready()));
    check("valid4", 32'(v4), 32'(q.size() != 0));
    check("valid3", 32'(v3), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("data4", d4, q[0].d4);
      check("err4", 32'(e4), 32'd0);
      check("data3", d3, q[0].d3);
      check("err3", 32'(e3), 32'(q[0].e3));
    end else if (!rstn) begin
      check("rst_data4", d4, 32'd0);
      check("rst_data3", d3, 32'd0);
      check("rst_err3", 32'(e3), 32'd0);
    end
    check("sticky4", 32'(s4), 32'd0);
    check("sticky3", 32'(s3), 32'(stk3));
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      acc = up_valid && exp_ready();
      xf  = (q.size() != 0) && dn_ready;
      b   = make_beat(sel, lanes);
      if (xf) void'(q.pop_front());
      if (acc) q.push_back(b);
      if (acc && b.e3) stk3 = 1'b1;
      else if (err_clr) stk3 = 1'b0;
      live  = 1'b1;
      rdy_m = (q.size() < 2);
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn     = 1'b1;
    up_valid = 1'b0;
    sel      = 2'd0;
    dn_ready = 1'b0;
    err_clr  = 1'b0;
    lanes    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    model_reset();
    #2 rstn = 1'b0;
    repeat (3) tick();

    // Release: ready must stay low until the first edge, then rise
    rstn = 1'b1;
    repeat (2) tick();

    // Streaming with no backpressure
    dn_ready = 1'b1;
    up_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
    end
    up_valid = 1'b0;
    repeat (2) tick();

    // Backpressure fills output then skid
    dn_ready = 1'b0;
    up_valid = 1'b1;
    sel = 2'd2; tick();
    sel = 2'd3; tick();
    sel = 2'd0; tick();
    #1;
`ifdef MUXN_PIPE_SKID_EN
    check("full_ready", 32'(rdy4), 32'd0);
`endif
    check("hold_data", d4, 32'h33333333);
    @(negedge clk);
    tick();
    dn_ready = 1'b1;
    repeat (4) tick();
    up_valid = 1'b0;
    repeat (2) tick();

    // Out-of-range select on the 3-input instance
    up_valid = 1'b1;
    sel = 2'd3; tick();
    sel = 2'd1; tick();
    up_valid = 1'b0;
    tick();
    check("sticky_held", 32'(s3), 32'd1);

    // Clear coincident with a new error: set wins; later a lone clear drops it
    up_valid = 1'b1; sel = 2'd3; err_clr = 1'b1; tick();
    up_valid = 1'b0; err_clr = 1'b0; tick();
    check("sticky_set_wins", 32'(s3), 32'd1);
    err_clr = 1'b1; tick();
    err_clr = 1'b0; tick();
    check("sticky_cleared", 32'(s3), 32'd0);

    // Asynchronous reset while holding two beats
    dn_ready = 1'b0;
    up_valid = 1'b1;
    sel = 2'd2; tick();
    sel = 2'd3; tick();
    up_valid = 1'b0;
    #3 rstn = 1'b0;
    #1;
    check("async_valid4", 32'(v4), 32'd0);
    check("async_data4", d4, 32'd0);
    check("async_valid3", 32'(v3), 32'd0);
    check("async_data3", d3, 32'd0);
    model_reset();
    repeat (2) tick();
    rstn = 1'b1;
    dn_ready = 1'b1;
    repeat (4) tick();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      up_valid = 1'($urandom_range(0, 1));
      sel      = 2'($urandom_range(0, 3));
      lanes    = {$urandom, $urandom, $urandom, $urandom};
      dn_ready = ($urandom_range(0, 3) != 0);
      err_clr  = ($urandom_range(0, 15) == 0);
      tick();
    end
    up_valid = 1'b0;
    dn_ready = 1'b1;
    err_clr  = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muxn_pipe.md
Name: muxn_pipe

Overview:
- Parametrised N-way data multiplexer with a registered output and a valid/ready handshake on both sides.
- Generalises the fixed 3-input combinational selector: configurable input count and width.
- Out-of-range selects produce a defined output and an error flag instead of X.
- Used wherever a selected operand must cross a pipeline boundary under backpressure, e.g. register-file read, writeback-source and CSR result paths.

Parameters:
- NUM_INPUTS, 4, number of data inputs; legal range 2..64.
- MUX_DATA_WIDTH, 32, width of each data input and of the output.
- SEL_WIDTH (localparam), $clog2(NUM_INPUTS), select width; not overridable.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream beat valid.
- o_ready  output  1  block can accept a beat this cycle.
- i_sel  input  SEL_WIDTH  select for the beat.
- i_in  input  NUM_INPUTS*MUX_DATA_WIDTH  flattened inputs; lane k at [k*MUX_DATA_WIDTH +: MUX_DATA_WIDTH].
- o_valid  output  1  output beat valid.
- i_ready  input  1  downstream accepts the output beat.
- o_muxout  output  MUX_DATA_WIDTH  selected data.
- o_sel_err  output  1  current output beat came from an out-of-range select.
- i_err_clr  input  1  clears o_err_sticky.
- o_err_sticky  output  1  set on any accepted out-of-range select; held until cleared.

Behaviour:
- Accept: i_valid & o_ready. Output transfer: o_valid & i_ready.
- Reset (i_rstn low, asynchronous): o_valid=0, o_muxout=0, o_sel_err=0, o_err_sticky=0, skid empty, o_ready=0. o_ready rises on the first clock edge after reset deassertion.
- Latency: a beat accepted at edge N appears on o_valid/o_muxout after edge N. One cycle; no combinational in-to-out data path.
- Selection: i_sel < NUM_INPUTS gives lane i_sel and sel_err=0. i_sel >= NUM_INPUTS (possible when NUM_INPUTS is not a power of 2) gives all-zero data and sel_err=1. sel_err is stored with the beat and moves with it through the skid.
- Skid buffer: one output register (OUT) plus one skid register (SKID). States:
  - EMPTY: OUT and SKID invalid.
  - ONE: OUT valid.
  - FULL: OUT and SKID valid.
- Transitions:
  - EMPTY -> ONE on accept.
  - ONE stays ONE on accept with output transfer (OUT reloads).
  - ONE -> EMPTY on transfer without accept.
  - ONE -> FULL on accept without transfer (beat goes to SKID).
  - FULL -> ONE on transfer (SKID moves to OUT).
  - FULL never accepts.
- o_ready is registered: high in EMPTY and ONE, low in FULL, low in reset. No combinational path from i_ready to o_ready.
- Output stability: while o_valid=1 and i_ready=0, o_muxout and o_sel_err hold.
- Throughput: one beat per cycle sustained while i_ready=1.
- Ordering: strict FIFO order, depth 2; no beat is dropped or duplicated.
- i_valid=1 while o_ready=0 is ignored; upstream must hold the beat.
- o_err_sticky sets on an accepted erroneous beat and clears on i_err_clr. If both happen in the same cycle, set wins.
- Reset mid-operation discards OUT and SKID contents immediately.

Optional Feature:
- Macro: MUXN_PIPE_SKID_EN.
- Defined: two-entry skid behaviour as specified above; o_ready is registered.
- Undefined:
  - SKID register and FULL state are removed.
  - o_ready = ~o_valid | i_ready, combinational.
  - Latency and output stability rules are unchanged.
  - Full throughput is still achieved, at the cost of a combinational ready path.
- The bench runs all scenarios in both builds. Expected FULL/o_ready values apply only when the macro is defined.

Test Plan:
- Reset, NUM_INPUTS=4, W=32, lanes {0x11111111,0x22222222,0x33333333,0x44444444} -> all outputs 0 during reset; o_ready=1 one edge after release.
- Streaming with i_ready=1, i_valid=1, i_sel=0,1,2,3 on consecutive cycles -> o_muxout = 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles, each one cycle after accept; no bubbles.
- Backpressure: i_ready=0, push sel=2 then sel=3 (both accepted); sel=0 offered -> o_ready=0 after the second accept (FULL). o_muxout holds 0x33333333. Release i_ready -> 0x33333333 then 0x44444444 out, then sel=0 accepted.
- NUM_INPUTS=3, i_sel=3 accepted -> o_muxout=0, o_sel_err=1, o_err_sticky=1. Next beat with i_sel=1 -> o_sel_err=0 while o_err_sticky stays 1.
- i_err_clr pulsed in the same cycle as a second out-of-range accept -> o_err_sticky remains 1. Later i_err_clr alone -> 0.
- Async reset asserted mid-cycle while FULL -> o_valid=0 and o_muxout=0 immediately, before the next edge. No stale beat emerges after release.
